// File: rtl/sop_scan_checker.sv
// -----------------------------------------------------------------------------
// sop_scan_checker
//
// Purpose:
//   Exhaustively compares two 3-input combinational implementations of the
//   same logic function. It steps the stimulus {x,y,z} through minterms 0..7.
//   Each vector is held for SETTLE wait cycles and then sampled for one cycle.
//   The checker records both truth tables and counts the disagreeing minterms.
//   It also records the lowest disagreeing minterm.
//
// Ports:
//   clk, reset           single clock; synchronous active-high reset
//   start                scan request, only honoured in IDLE
//   s_a, s_b             outputs of implementation A and B
//   x, y, z              stimulus to both implementations (x is the MSB)
//   busy                 high while a scan is in progress (WAIT or SAMPLE)
//   done                 one-cycle pulse when a scan completes
//   tt_a, tt_b           captured truth tables; bit i = output for minterm i
//   mism_count           number of minterms where s_a != s_b (0..8)
//   first_mism           lowest mismatching minterm (meaningful if mism_count!=0)
//   equal                combinational (mism_count == 0)
//   fsm_state            current FSM state: 0 IDLE, 1 WAIT, 2 SAMPLE, 3 DONE
//
// Handshake: start is a level.
//   It is accepted on a rising edge where the FSM is IDLE, and ignored at all
//   other times.
//   If start is held high, a new scan begins on the first IDLE cycle after DONE.
//   Results stay stable from DONE until the next accepted start.
// -----------------------------------------------------------------------------
module sop_scan_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s_a,
  input  logic       s_b,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_a,
  output logic [7:0] tt_b,
  output logic [3:0] mism_count,
  output logic [2:0] first_mism,
  output logic       equal,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;

  assign equal     = (mism_count == 4'd0);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 3'd0;
      cnt        <= 4'd0;
      {x, y, z}  <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt_a       <= 8'h00;
      tt_b       <= 8'h00;
      mism_count <= 4'd0;
      first_mism <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          {x, y, z} <= 3'b000;
          busy      <= 1'b0;
          if (start) begin
            tt_a       <= 8'h00;
            tt_b       <= 8'h00;
            mism_count <= 4'd0;
            first_mism <= 3'd0;
            idx        <= 3'd0;
            cnt        <= SETTLE_L;
            busy       <= 1'b1;
            state      <= S_WAIT;
          end
        end

        // The counter holds the number of wait cycles left, including the
        // current cycle, so the last wait cycle is the one where it reads 1.
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          tt_a[idx] <= s_a;
          tt_b[idx] <= s_b;
          if (s_a != s_b) begin
            mism_count <= mism_count + 4'd1;
            if (mism_count == 4'd0) begin
              first_mism <= idx;
            end
          end
          if (idx == 3'd7) begin
            // The last minterm has been sampled. Park the stimulus at 000 and
            // raise done for the single DONE cycle.
            {x, y, z} <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b1;
            cnt       <= 4'd0;
            state     <= S_DONE;
          end else begin
            idx       <= idx + 3'd1;
            {x, y, z} <= idx + 3'd1;
            cnt       <= SETTLE_L;
            state     <= S_WAIT;
          end
        end

        S_DONE: begin
          idx   <= 3'd0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sop_scan_checker.sv
// -----------------------------------------------------------------------------
// tb_sop_scan_checker
//
// Purpose:
//   Directed tests for sop_scan_checker.
//   dut1 uses SETTLE=1 and dut3 uses SETTLE=3.
//   Both implementations are modelled as truth-table lookups (fa, fb), indexed
//   by the stimulus the DUT drives.
//   Inputs are driven at the falling edge, and outputs are sampled at the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_sop_scan_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic [7:0] fa = 8'h00;
  logic [7:0] fb = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  // dut1 signals
  logic x1, y1, z1, busy1, done1, equal1, sa1, sb1;
  logic [7:0] tt_a1, tt_b1;
  logic [3:0] mism1;
  logic [2:0] first1, xyz1;
  logic [1:0] st1;

  // dut3 signals
  logic x3, y3, z3, busy3, done3, equal3, sa3, sb3;
  logic [7:0] tt_a3, tt_b3;
  logic [3:0] mism3;
  logic [2:0] first3, xyz3;
  logic [1:0] st3;

  assign xyz1 = {x1, y1, z1};
  assign xyz3 = {x3, y3, z3};
  assign sa1  = fa[xyz1];
  assign sb1  = fb[xyz1];
  assign sa3  = fa[xyz3];
  assign sb3  = fb[xyz3];

  always #5 clk = ~clk;

  sop_scan_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .s_a(sa1), .s_b(sb1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
    .tt_a(tt_a1), .tt_b(tt_b1), .mism_count(mism1), .first_mism(first1),
    .equal(equal1), .fsm_state(st1)
  );

  sop_scan_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .s_a(sa3), .s_b(sb3),
    .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3),
    .tt_a(tt_a3), .tt_b(tt_b3), .mism_count(mism3), .first_mism(first3),
    .equal(equal3), .fsm_state(st3)
  );

  // Run one dut1 scan and return the number of edges from start acceptance
  // to the cycle where done is seen. The result is -1 on timeout.
  task automatic run_scan1(input logic [7:0] a, input logic [7:0] b, output int lat);
    fa = a;
    fb = b;
    @(negedge clk);
    start1 = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 1) start1 = 1'b0;
      if (done1) lat = i - 1;
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    start1 = 1'b1;   // reset must win over start
    repeat (3) @(negedge clk);
    n_checks++; if (st1 !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", st1); end
    n_checks++; if (xyz1 !== 3'd0) begin n_fail++; $display("FAIL reset_xyz: got %b expected 000", xyz1); end
    n_checks++; if ({busy1, done1} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {busy1, done1}); end
    n_checks++; if ({tt_a1, tt_b1} !== 16'h0000) begin n_fail++; $display("FAIL reset_tt: got %h expected 0000", {tt_a1, tt_b1}); end
    n_checks++; if ({mism1, first1} !== 7'd0) begin n_fail++; $display("FAIL reset_mism: got %h expected 0", {mism1, first1}); end
    n_checks++; if (equal1 !== 1'b1) begin n_fail++; $display("FAIL reset_equal: got %b expected 1", equal1); end
    reset  = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    n_checks++; if (st1 !== 2'd0 || busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after: got st=%0d busy3=%b expected 0 0", st1, busy3); end
  endtask

  task automatic test_equal_functions;
    int lat;
    run_scan1(8'hC5, 8'hC5, lat);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL eq_latency: got %0d expected 16", lat); end
    n_checks++; if (tt_a1 !== 8'hC5 || tt_b1 !== 8'hC5) begin n_fail++; $display("FAIL eq_tt: got %h/%h expected c5/c5", tt_a1, tt_b1); end
    n_checks++; if (mism1 !== 4'd0 || equal1 !== 1'b1) begin n_fail++; $display("FAIL eq_mism: got %0d eq=%b expected 0 eq=1", mism1, equal1); end
    n_checks++; if (busy1 !== 1'b0 || st1 !== 2'd3) begin n_fail++; $display("FAIL eq_done_state: got busy=%b st=%0d expected 0 3", busy1, st1); end
    @(negedge clk);
    n_checks++; if (done1 !== 1'b0 || st1 !== 2'd0) begin n_fail++; $display("FAIL eq_done_pulse: got done=%b st=%0d expected 0 0", done1, st1); end
    repeat (5) @(negedge clk);
    n_checks++; if (tt_a1 !== 8'hC5 || mism1 !== 4'd0) begin n_fail++; $display("FAIL eq_hold: got %h %0d expected c5 0", tt_a1, mism1); end
  endtask

  task automatic test_mismatch;
    int lat;
    run_scan1(8'hC5, 8'h8E, lat);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL mm_latency: got %0d expected 16", lat); end
    n_checks++; if (tt_a1 !== 8'hC5 || tt_b1 !== 8'h8E) begin n_fail++; $display("FAIL mm_tt: got %h/%h expected c5/8e", tt_a1, tt_b1); end
    n_checks++; if (mism1 !== 4'd4 || first1 !== 3'd0 || equal1 !== 1'b0) begin n_fail++; $display("FAIL mm_count: got %0d first=%0d eq=%b expected 4 0 0", mism1, first1, equal1); end
    run_scan1(8'h00, 8'hF0, lat);
    n_checks++; if (mism1 !== 4'd4 || first1 !== 3'd4) begin n_fail++; $display("FAIL mm_upper: got %0d first=%0d expected 4 4", mism1, first1); end
    run_scan1(8'h00, 8'hFF, lat);
    n_checks++; if (mism1 !== 4'd8 || first1 !== 3'd0 || tt_b1 !== 8'hFF) begin n_fail++; $display("FAIL mm_all: got %0d first=%0d tt_b=%h expected 8 0 ff", mism1, first1, tt_b1); end
    run_scan1(8'hFF, 8'h7F, lat);
    n_checks++; if (mism1 !== 4'd1 || first1 !== 3'd7) begin n_fail++; $display("FAIL mm_last: got %0d first=%0d expected 1 7", mism1, first1); end
  endtask

  task automatic test_settle3;
    int lat = -1;
    int errs = 0;
    fa = 8'hC5;
    fb = 8'h8E;
    @(negedge clk);
    start3 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start3 = 1'b0;
      if (i <= 32 && (xyz3 !== 3'((i - 1) / 4) || busy3 !== 1'b1)) errs++;
      if (done3 && lat < 0) lat = i - 1;
    end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL s3_stepping: got %0d bad cycles expected 0", errs); end
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL s3_latency: got %0d expected 32", lat); end
    n_checks++; if (tt_a3 !== 8'hC5 || tt_b3 !== 8'h8E || mism3 !== 4'd4) begin n_fail++; $display("FAIL s3_result: got %h/%h %0d expected c5/8e 4", tt_a3, tt_b3, mism3); end
  endtask

  task automatic test_start_ignored;
    int lat = -1;
    int ndone = 0;
    int pulsed_at = 0;
    fa = 8'hC5;
    fb = 8'h8E;
    @(negedge clk);
    start1 = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1 || (pulsed_at != 0 && i == pulsed_at + 1)) start1 = 1'b0;
      if (pulsed_at == 0 && xyz1 == 3'd3) begin
        start1 = 1'b1;
        pulsed_at = i;
      end
      if (done1) begin
        ndone++;
        if (lat < 0) lat = i - 1;
      end
    end
    n_checks++; if (pulsed_at == 0 || ndone !== 1) begin n_fail++; $display("FAIL ign_single_done: got %0d dones (pulse at %0d) expected 1", ndone, pulsed_at); end
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL ign_latency: got %0d expected 16", lat); end
    n_checks++; if (tt_a1 !== 8'hC5 || tt_b1 !== 8'h8E || mism1 !== 4'd4 || first1 !== 3'd0) begin n_fail++; $display("FAIL ign_result: got %h/%h %0d %0d expected c5/8e 4 0", tt_a1, tt_b1, mism1, first1); end
  endtask

  task automatic test_reset_mid_scan;
    int lat;
    int ndone = 0;
    bit found = 0;
    fa = 8'hC5;
    fb = 8'h8E;
    @(negedge clk);
    start1 = 1'b1;
    for (int i = 1; i <= 30 && !found; i++) begin
      @(negedge clk);
      if (i == 1) start1 = 1'b0;
      if (xyz1 == 3'd5) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rst_mid_reach: got no idx 5 expected idx 5"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if ({xyz1, busy1, done1, tt_a1, tt_b1, mism1, first1} !== 28'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", {xyz1, busy1, done1, tt_a1, tt_b1, mism1, first1}); end
    n_checks++; if (st1 !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected 0", st1); end
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d expected 0", ndone); end
    run_scan1(8'hC5, 8'h8E, lat);
    n_checks++; if (lat !== 16 || tt_a1 !== 8'hC5 || tt_b1 !== 8'h8E || mism1 !== 4'd4) begin n_fail++; $display("FAIL rst_mid_rescan: got lat=%0d %h/%h %0d expected 16 c5/8e 4", lat, tt_a1, tt_b1, mism1); end
  endtask

  task automatic test_back_to_back;
    int t[3];
    int ndone = 0;
    int errs = 0;
    int extra = 0;
    fa = 8'h00;
    fb = 8'hF0;
    @(negedge clk);
    start1 = 1'b1;
    for (int i = 1; i <= 80 && ndone < 3; i++) begin
      @(negedge clk);
      if (done1) begin
        t[ndone] = i - 1;
        ndone++;
        if (tt_a1 !== 8'h00 || tt_b1 !== 8'hF0 || mism1 !== 4'd4 || first1 !== 3'd4) errs++;
      end
    end
    start1 = 1'b0;
    n_checks++; if (ndone !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", ndone); end
    n_checks++; if (t[0] !== 16 || t[1] - t[0] !== 18 || t[2] - t[1] !== 18) begin n_fail++; $display("FAIL b2b_period: got %0d %0d %0d expected 16 34 52", t[0], t[1], t[2]); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL b2b_results: got %0d bad results expected 0", errs); end
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1 || busy1) extra++;
    end
    n_checks++; if (extra !== 0 || st1 !== 2'd0) begin n_fail++; $display("FAIL b2b_stop: got %0d active cycles st=%0d expected 0 0", extra, st1); end
  endtask

  initial begin
    test_reset;
    test_equal_functions;
    test_mismatch;
    test_settle3;
    test_start_ignored;
    test_reset_mid_scan;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
